// File: rtl/lau_pkg.sv
// Shared arithmetic-unit types: the prefix-logic performance selector.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents:
//   speed_e  SLOW = ripple prefix chain (smallest, longest path)
//            FAST = Kogge-Stone prefix tree (log2 depth)
package lau_pkg;

  typedef enum logic {
    SLOW = 1'b0,
    FAST = 1'b1
  } speed_e;

endpackage : lau_pkg

// File: rtl/IncDec.sv
// Incrementer/decrementer: z_o = a_i + 1 (dec_i=0) or a_i - 1 (dec_i=1), modulo 2^width.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output always valid for the current inputs.
//
// Ports:
//   a_i    [width-1:0]  operand (A)
//   dec_i               direction (DEC): 1 = decrement, 0 = increment
//   z_o    [width-1:0]  result
//
// Parameters:
//   width  operand width, legal range 2..64
//   speed  lau_pkg::speed_e, selects ripple (SLOW) or Kogge-Stone (FAST) prefix
module IncDec
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] a_i,
  input  logic             dec_i,
  output logic [width-1:0] z_o
);

  // Bit i toggles when every lower bit "propagates": all ones for an
  // increment, all zeros for a decrement. Only bits 0..width-2 can feed a
  // higher bit, so the MSB never enters the prefix network.
  localparam int pw     = width - 1;
  localparam int levels = (pw > 1) ? $clog2(pw) : 0;

  logic [pw-1:0]    prop;
  logic [width-1:0] toggle;

  assign prop = a_i[pw-1:0] ^ {pw{dec_i}};

  if (speed == FAST) begin : g_fast
    // lvl[l][i] = AND of prop[i-(2^l)+1 .. i], clipped at bit 0.
    logic [levels:0][pw-1:0] lvl;

    assign lvl[0] = prop;

    for (genvar l = 0; l < levels; l++) begin : g_lvl
      for (genvar i = 0; i < pw; i++) begin : g_bit
        if (i >= (1 << l)) begin : g_and
          assign lvl[l+1][i] = lvl[l][i] & lvl[l][i-(1<<l)];
        end else begin : g_pass
          assign lvl[l+1][i] = lvl[l][i];
        end
      end
    end

    assign toggle = {lvl[levels], 1'b1};
  end else begin : g_slow
    logic [width-1:0] chain;

    always_comb begin
      logic acc;
      acc      = 1'b1;
      chain[0] = 1'b1;
      for (int i = 1; i < width; i++) begin
        acc      = acc & prop[i-1];
        chain[i] = acc;
      end
    end

    assign toggle = chain;
  end

  assign z_o = a_i ^ toggle;

endmodule : IncDec

// File: rtl/updown_counter.sv
// Up/down counter with synchronous clear/load, terminal count and wrap pulse.
// Latency: one cycle from clr_i/load_i/en_i to count_o and wrap_o; tc_o is combinational.
// Backpressure: none; every enabled cycle takes exactly one step.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset (count_o = 0, wrap_o = 0)
//   clr_i       synchronous clear (highest priority)
//   load_i      synchronous load of load_val_i
//   load_val_i  [width-1:0] load value
//   en_i        count enable, one step per enabled cycle
//   dec_i       direction: 1 = down, 0 = up
//   count_o     [width-1:0] registered count
//   tc_o        terminal count: count at max going up, or at 0 going down
//   wrap_o      registered one-cycle pulse after a step taken at terminal count
//
// Build option: define UPDOWN_COUNTER_SATURATE_EN to make a step at terminal
// count hold the value instead of wrapping; wrap_o then flags saturation.
module updown_counter
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [width-1:0] load_val_i,
  input  logic             en_i,
  input  logic             dec_i,
  output logic [width-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_o
);

  logic [width-1:0] count_q;
  logic [width-1:0] count_d;
  logic [width-1:0] step;
  logic             wrap_q;
  logic             wrap_d;
  logic             tc;

  IncDec #(
    .width (width),
    .speed (speed)
  ) u_incdec (
    .a_i   (count_q),
    .dec_i (dec_i),
    .z_o   (step)
  );

  // The live dec_i selects which boundary counts as terminal, so a direction
  // change in the same cycle as en_i is judged against the new direction.
  assign tc = dec_i ? (count_q == '0) : (count_q == '1);

  // Priority: clear > load > step > hold. Only a step can raise wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      wrap_d = tc;
`ifdef UPDOWN_COUNTER_SATURATE_EN
      if (!tc) begin
        count_d = step;
      end
`else
      count_d = step;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc;
  assign wrap_o  = wrap_q;

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: directed 8-bit scenarios, then randomized
// control at 16 and 32 bits for both speed settings against a reference model.
module tb_updown_counter;
  import lau_pkg::*;

`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  int ncmp = 0;
  int nerr = 0;

  // 8-bit directed instance
  logic       clr8, load8, en8, dec8;
  logic [7:0] lv8, cnt8;
  logic       tc8, wrap8;

  updown_counter #(.width(8), .speed(FAST)) u_w8 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr8), .load_i(load8),
    .load_val_i(lv8), .en_i(en8), .dec_i(dec8),
    .count_o(cnt8), .tc_o(tc8), .wrap_o(wrap8)
  );

  // Randomized group: shared controls, four configurations
  logic        clr_r, load_r, en_r, dec_r;
  logic [31:0] lv_r;
  logic [15:0] c0, c1;
  logic [31:0] c2, c3;
  logic [3:0]  tc_r, wrap_r;
  logic [63:0] cnt_a [4];

  updown_counter #(.width(16), .speed(FAST)) u_w16f (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_r), .load_i(load_r),
    .load_val_i(lv_r[15:0]), .en_i(en_r), .dec_i(dec_r),
    .count_o(c0), .tc_o(tc_r[0]), .wrap_o(wrap_r[0])
  );
  updown_counter #(.width(16), .speed(SLOW)) u_w16s (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_r), .load_i(load_r),
    .load_val_i(lv_r[15:0]), .en_i(en_r), .dec_i(dec_r),
    .count_o(c1), .tc_o(tc_r[1]), .wrap_o(wrap_r[1])
  );
  updown_counter #(.width(32), .speed(FAST)) u_w32f (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_r), .load_i(load_r),
    .load_val_i(lv_r), .en_i(en_r), .dec_i(dec_r),
    .count_o(c2), .tc_o(tc_r[2]), .wrap_o(wrap_r[2])
  );
  updown_counter #(.width(32), .speed(SLOW)) u_w32s (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_r), .load_i(load_r),
    .load_val_i(lv_r), .en_i(en_r), .dec_i(dec_r),
    .count_o(c3), .tc_o(tc_r[3]), .wrap_o(wrap_r[3])
  );

  assign cnt_a[0] = {48'd0, c0};
  assign cnt_a[1] = {48'd0, c1};
  assign cnt_a[2] = {32'd0, c2};
  assign cnt_a[3] = {32'd0, c3};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the randomized group
  int                 wid [4] = '{16, 16, 32, 32};
  longint unsigned    m   [4];
  logic               mw  [4];

  initial begin
    rst_n = 1'b0;
    clr8 = 0; load8 = 0; en8 = 0; dec8 = 0; lv8 = '0;
    clr_r = 0; load_r = 0; en_r = 0; dec_r = 0; lv_r = '0;

    // Reset state and tc following dec with count = 0
    #2;
    check("rst_cnt", cnt8, 0);
    check("rst_wrap", wrap8, 0);
    check("rst_tc_up", tc8, 0);
    dec8 = 1;
    #1;
    check("rst_tc_dn", tc8, 1);
    dec8 = 0;
    tick();
    rst_n = 1'b1;

    // Count up 1, 2, 3
    en8 = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("up_cnt%0d", i), cnt8, i);
      check($sformatf("up_wrap%0d", i), wrap8, 0);
    end

    // Up through max
    en8 = 0; load8 = 1; lv8 = 8'hFF;
    tick();
    check("load_ff", cnt8, 8'hFF);
    load8 = 0; en8 = 1;
    #1;
    check("tc_at_max", tc8, 1);
    tick();
    check("wrap_up_cnt", cnt8, SAT ? 8'hFF : 8'h00);
    check("wrap_up_pulse", wrap8, 1);
    en8 = 0;
    tick();
    check("wrap_up_drop", wrap8, 0);
    check("hold_cnt", cnt8, SAT ? 8'hFF : 8'h00);

    // Down through zero
    clr8 = 1;
    tick();
    check("clr_cnt", cnt8, 0);
    clr8 = 0; en8 = 1; dec8 = 1;
    #1;
    check("tc_at_zero", tc8, 1);
    tick();
    check("wrap_dn_cnt", cnt8, SAT ? 8'h00 : 8'hFF);
    check("wrap_dn_pulse", wrap8, 1);
    en8 = 0; dec8 = 0;
    tick();
    check("wrap_dn_drop", wrap8, 0);

    // Priority: clear beats load and enable; load beats enable
    clr8 = 1; load8 = 1; lv8 = 8'h55; en8 = 1;
    tick();
    check("prio_clr_cnt", cnt8, 0);
    check("prio_clr_wrap", wrap8, 0);
    clr8 = 0;
    tick();
    check("prio_load_cnt", cnt8, 8'h55);
    check("prio_load_wrap", wrap8, 0);

    // Load at terminal with enable: no step, no wrap
    lv8 = 8'hFF;
    tick();
    lv8 = 8'h10;
    tick();
    check("load_en_tc_cnt", cnt8, 8'h10);
    check("load_en_tc_wrap", wrap8, 0);

    // Async reset mid-count, then first edge after release counts normally
    load8 = 0;
    tick();
    tick();
    check("pre_rst_cnt", cnt8, 8'h12);
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", cnt8, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_cnt", cnt8, 1);

    // Async reset clears a live wrap pulse
    en8 = 0; load8 = 1; lv8 = 8'hFF;
    tick();
    load8 = 0; en8 = 1;
    tick();
    check("pre_rst_wrap", wrap8, 1);
    en8 = 0;
    rst_n = 1'b0;
    #1;
    check("async_rst_wrap", wrap8, 0);
    check("async_rst_cnt2", cnt8, 0);
    rst_n = 1'b1;
    tick();

    // Randomized phase: the wide instances have been reset with idle inputs
    for (int k = 0; k < 4; k++) begin
      m[k]  = 0;
      mw[k] = 1'b0;
    end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      clr_r  = ($urandom_range(15) == 0);
      load_r = ($urandom_range(7) == 0);
      en_r   = ($urandom_range(3) != 0);
      if ($urandom_range(3) == 0) dec_r = ~dec_r;
      case ($urandom_range(5))
        0:       lv_r = 32'h0000_0000;
        1:       lv_r = 32'hFFFF_FFFF;
        2:       lv_r = 32'h0000_FFFF;
        3:       lv_r = 32'hFFFF_FFFE;
        4:       lv_r = 32'h0000_0001;
        default: lv_r = $urandom;
      endcase
      #1;
      for (int k = 0; k < 4; k++) begin
        longint unsigned mask;
        logic            tcm;
        mask = (64'd1 << wid[k]) - 64'd1;
        tcm  = dec_r ? (m[k] == 0) : (m[k] == mask);
        check($sformatf("rnd%0d_tc_c%0d", k, cyc), tc_r[k], tcm);
        if (clr_r) begin
          m[k] = 0;  mw[k] = 1'b0;
        end else if (load_r) begin
          m[k] = lv_r & mask;  mw[k] = 1'b0;
        end else if (en_r) begin
          mw[k] = tcm;
          if (!(SAT && tcm))
            m[k] = dec_r ? ((m[k] - 1) & mask) : ((m[k] + 1) & mask);
        end else begin
          mw[k] = 1'b0;
        end
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rnd%0d_cnt_c%0d", k, cyc), cnt_a[k], m[k]);
        check($sformatf("rnd%0d_wrap_c%0d", k, cyc), wrap_r[k], mw[k]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule : tb_updown_counter
